// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver.
// Sample instants are fixed by the detected start edge; reports framing and overrun.
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1000
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 in,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int NB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BW = $clog2(NB + 1);

    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic                 sync_q1;
    logic                 sync_in;
    logic [1:0]           fill;
    logic                 sync_ok;

    logic [1:0]           state;
    logic                 armed;
    logic [CW-1:0]        ctr;
    logic [BW-1:0]        bit_ctr;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_err;
    logic                 done;
    logic                 done_err;

    // The reset value of the synchronizer is not a real line sample, so
    // arming waits until both flops have been loaded from the line.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q1 <= 1'b1;
            sync_in <= 1'b1;
            fill    <= 2'b00;
        end else begin
            sync_q1 <= in;
            sync_in <= sync_q1;
            fill    <= {fill[0], 1'b1};
        end
    end

    assign sync_ok = fill[1];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            armed    <= 1'b0;
            ctr      <= '0;
            bit_ctr  <= '0;
            shreg    <= '0;
            stop_err <= 1'b0;
            done     <= 1'b0;
            done_err <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    ctr      <= '0;
                    bit_ctr  <= '0;
                    stop_err <= 1'b0;
                    if (sync_ok && sync_in) begin
                        armed <= 1'b1;
                    end
                    if (armed && !sync_in) begin
                        state <= START;
                    end
                end
                START: begin
                    if (ctr == HALF) begin
                        ctr   <= '0;
                        state <= sync_in ? IDLE : DATA;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                DATA: begin
                    if (ctr == LAST) begin
                        ctr   <= '0;
                        shreg <= {sync_in, shreg[DATA_BITS-1:1]};
                        if (bit_ctr == DLAST) begin
                            bit_ctr <= '0;
                            state   <= STOP;
                        end else begin
                            bit_ctr <= bit_ctr + 1'b1;
                        end
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                STOP: begin
                    if (ctr == LAST) begin
                        ctr <= '0;
                        if (bit_ctr == SLAST) begin
                            bit_ctr  <= '0;
                            state    <= IDLE;
                            done     <= 1'b1;
                            done_err <= stop_err | ~sync_in;
                        end else begin
                            bit_ctr  <= bit_ctr + 1'b1;
                            stop_err <= stop_err | ~sync_in;
                        end
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A completion always wins over a plain ack; overrun only grows
    // when an unacknowledged word is replaced.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (done) begin
            data_out  <= shreg;
            frame_err <= done_err;
            valid     <= 1'b1;
            if (valid && !ack) begin
                overrun <= 1'b1;
            end
        end else if (ack && valid) begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule
